// File: rtl/timer_config_sequencer_if.sv
// Command channel between a bus-side master and the timer config sequencer.
// The master presents one command at a time. The accompanying cfg_* fields
// are only meaningful in the cycle where req_valid and req_ready are both high.
interface timer_config_sequencer_if #(
  parameter int COUNTER_BIT_WIDTH = 8
);
  logic                         req_valid;
  logic                         req_ready;
  logic [1:0]                   req_op;
  logic [COUNTER_BIT_WIDTH-6:0] cfg_prescaler;
  logic [COUNTER_BIT_WIDTH-1:0] cfg_count_max;
  logic [COUNTER_BIT_WIDTH-1:0] cfg_count_min;
  logic [COUNTER_BIT_WIDTH-1:0] cfg_cmp_0;
  logic [COUNTER_BIT_WIDTH-1:0] cfg_cmp_1;
  logic [3:0]                   cfg_mode;

  modport master (
    output req_valid, req_op, cfg_prescaler, cfg_count_max, cfg_count_min,
           cfg_cmp_0, cfg_cmp_1, cfg_mode,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, cfg_prescaler, cfg_count_max, cfg_count_min,
           cfg_cmp_0, cfg_cmp_1, cfg_mode,
    output req_ready
  );
endinterface

// File: rtl/timer_config_sequencer.sv
// Converts high-level timer commands into ordered single-cycle register writes
// on the timer's configuration port. It also keeps a shadow copy of the last
// loaded configuration, which RESTART and STOP use.
module timer_config_sequencer #(
  parameter int         COUNTER_BIT_WIDTH = 8,
  parameter logic [3:0] ADDR_CTRL         = 4'd0,
  parameter logic [3:0] ADDR_PRESCALER    = 4'd1,
  parameter logic [3:0] ADDR_MAX          = 4'd2,
  parameter logic [3:0] ADDR_MIN          = 4'd3,
  parameter logic [3:0] ADDR_CMP0         = 4'd4,
  parameter logic [3:0] ADDR_CMP1         = 4'd5
) (
  input  logic                         clk,
  input  logic                         rst,
  timer_config_sequencer_if.slave      cmd,
  output logic [3:0]                   config_address,
  output logic                         config_write_enable,
  output logic [COUNTER_BIT_WIDTH-1:0] write_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);
  localparam int W = COUNTER_BIT_WIDTH;

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_PRE, W_MAX, W_MIN, W_CMP0, W_CMP1, W_START, ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00, OP_STOP = 2'b01, OP_RESTART = 2'b10, OP_UPD = 2'b11
  } op_e;

  // The shadow doubles as the working copy that the write sequence reads from.
  typedef struct packed {
    logic [3:0]   mode;
    logic [W-6:0] pre;
    logic [W-1:0] max;
    logic [W-1:0] min;
    logic [W-1:0] cmp0;
    logic [W-1:0] cmp1;
  } shadow_t;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  shadow_t      sh_q, sh_d;
  logic         sh_valid_q, sh_valid_d;
  logic         we_q, we_d;
  logic [3:0]   addr_q, addr_d;
  logic [W-1:0] data_q, data_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  // Layout of the control word: {cmp1_en, cmp0_en, clk_sel, count_mode, start}.
  function automatic logic [W-1:0] ctrl_word(input logic [3:0] mode, input logic start);
    logic [W-1:0] w;
    w      = '0;
    w[4:0] = {mode, start};
    return w;
  endfunction

  // Command acceptance, shadow update and write-sequence stepping
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sh_d       = sh_q;
    sh_valid_d = sh_valid_q;
    case (state_q)
      IDLE: if (cmd.req_valid) begin
        op_d = op_e'(cmd.req_op);
        case (op_e'(cmd.req_op))
          OP_LOAD: if (cmd.cfg_count_min > cmd.cfg_count_max) state_d = ERR;
                   else begin
                     sh_d       = '{mode: cmd.cfg_mode, pre: cmd.cfg_prescaler,
                                    max: cmd.cfg_count_max, min: cmd.cfg_count_min,
                                    cmp0: cmd.cfg_cmp_0, cmp1: cmd.cfg_cmp_1};
                     sh_valid_d = 1'b1;
                     state_d    = W_STOP;
                   end
          OP_STOP:    state_d = W_STOP;
          OP_RESTART: state_d = sh_valid_q ? W_STOP : ERR;
          default:    if (!sh_valid_q) state_d = ERR;
                      else begin
                        sh_d.cmp0 = cmd.cfg_cmp_0;
                        sh_d.cmp1 = cmd.cfg_cmp_1;
                        state_d   = W_CMP0;
                      end
        endcase
      end
      W_STOP:  state_d = (op_q == OP_LOAD)    ? W_PRE   :
                         (op_q == OP_RESTART) ? W_START : IDLE;
      W_PRE:   state_d = W_MAX;
      W_MAX:   state_d = W_MIN;
      W_MIN:   state_d = W_CMP0;
      W_CMP0:  state_d = W_CMP1;
      W_CMP1:  state_d = (op_q == OP_LOAD) ? W_START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered write port: decode the write for the state being entered next,
  // so the strobe, address and data all change together on the same clock edge.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_d)
      W_STOP:  begin
        we_d = 1'b1; addr_d = ADDR_CTRL;
        data_d = ctrl_word(sh_valid_d ? sh_d.mode : 4'd0, 1'b0);
        done_d = (op_d == OP_STOP);
      end
      W_PRE:   begin we_d = 1'b1; addr_d = ADDR_PRESCALER; data_d = {5'd0, sh_d.pre}; end
      W_MAX:   begin we_d = 1'b1; addr_d = ADDR_MAX;  data_d = sh_d.max;  end
      W_MIN:   begin we_d = 1'b1; addr_d = ADDR_MIN;  data_d = sh_d.min;  end
      W_CMP0:  begin we_d = 1'b1; addr_d = ADDR_CMP0; data_d = sh_d.cmp0; end
      W_CMP1:  begin
        we_d = 1'b1; addr_d = ADDR_CMP1; data_d = sh_d.cmp1;
        done_d = (op_d == OP_UPD);
      end
      W_START: begin
        we_d = 1'b1; addr_d = ADDR_CTRL; data_d = ctrl_word(sh_d.mode, 1'b1);
        done_d = 1'b1;
      end
      ERR:     err_d = 1'b1;
      default: ;
    endcase
  end

  // State, shadow and output registers; reset abandons any sequence in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD;
      sh_q       <= '0;
      sh_valid_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sh_q       <= sh_d;
      sh_valid_q <= sh_valid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd.req_ready          = (state_q == IDLE);
  assign busy                   = (state_q != IDLE);
  assign config_write_enable    = we_q;
  assign config_address         = addr_q;
  assign write_data             = data_q;
  assign done                   = done_q;
  assign error                  = err_q;
endmodule

// File: tb/tb_timer_config_sequencer.sv
// Bench for timer_config_sequencer. It runs a table of directed commands,
// a mid-sequence reset, and randomized commands checked against a model
// that tracks the shadow configuration.
module tb_timer_config_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   config_address;
  logic         config_write_enable;
  logic [W-1:0] write_data;
  logic         busy, done, error;

  always #5 clk = ~clk;

  timer_config_sequencer_if #(.COUNTER_BIT_WIDTH(W)) cmd_if();

  timer_config_sequencer #(.COUNTER_BIT_WIDTH(W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd                 (cmd_if),
    .config_address      (config_address),
    .config_write_enable (config_write_enable),
    .write_data          (write_data),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model of the shadow configuration.
  bit         m_valid;
  logic [3:0] m_mode;
  logic [2:0] m_pre;
  logic [7:0] m_max, m_min, m_c0, m_c1;

  // Each expected write is packed as {addr[3:0], data[7:0]}.
  task automatic model(input logic [1:0] op, input logic [2:0] pre,
                       input logic [7:0] mx, input logic [7:0] mn,
                       input logic [7:0] c0, input logic [7:0] c1,
                       input logic [3:0] mode,
                       output bit err, output int n, output logic [6:0][11:0] wr);
    logic [7:0] stop_w, start_w;
    wr = '0; err = 0; n = 0;
    case (op)
      2'd0: if (mn > mx) err = 1;
            else begin
              m_valid = 1; m_mode = mode; m_pre = pre; m_max = mx; m_min = mn;
              m_c0 = c0; m_c1 = c1;
              stop_w  = 8'(m_mode) * 8'd2;
              start_w = stop_w + 8'd1;
              wr[0] = {4'd0, stop_w}; wr[1] = {4'd1, 5'd0, m_pre};
              wr[2] = {4'd2, m_max};  wr[3] = {4'd3, m_min};
              wr[4] = {4'd4, m_c0};   wr[5] = {4'd5, m_c1};
              wr[6] = {4'd0, start_w}; n = 7;
            end
      2'd1: begin
              stop_w = m_valid ? 8'(m_mode) * 8'd2 : 8'd0;
              wr[0] = {4'd0, stop_w}; n = 1;
            end
      2'd2: if (!m_valid) err = 1;
            else begin
              stop_w = 8'(m_mode) * 8'd2;
              wr[0] = {4'd0, stop_w}; wr[1] = {4'd0, stop_w + 8'd1}; n = 2;
            end
      default: if (!m_valid) err = 1;
               else begin
                 m_c0 = c0; m_c1 = c1;
                 wr[0] = {4'd4, m_c0}; wr[1] = {4'd5, m_c1}; n = 2;
               end
    endcase
  endtask

  task automatic scramble_cfg();
    cmd_if.req_op        = 2'($urandom);
    cmd_if.cfg_prescaler = 3'($urandom);
    cmd_if.cfg_count_max = 8'($urandom);
    cmd_if.cfg_count_min = 8'($urandom);
    cmd_if.cfg_cmp_0     = 8'($urandom);
    cmd_if.cfg_cmp_1     = 8'($urandom);
    cmd_if.cfg_mode      = 4'($urandom);
  endtask

  // Called just after a falling edge while the DUT is expected to be idle.
  // It drives one command, then checks every following cycle through the
  // return to idle. The bench samples on falling edges.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] pre,
                         input logic [7:0] mx, input logic [7:0] mn,
                         input logic [7:0] c0, input logic [7:0] c1, input logic [3:0] mode,
                         input bit err, input int n, input logic [6:0][11:0] wr);
    cmd_if.req_valid = 1'b1; cmd_if.req_op = op; cmd_if.cfg_prescaler = pre;
    cmd_if.cfg_count_max = mx; cmd_if.cfg_count_min = mn;
    cmd_if.cfg_cmp_0 = c0; cmd_if.cfg_cmp_1 = c1; cmd_if.cfg_mode = mode;
    check($sformatf("%s ready_at_req", tag), cmd_if.req_ready, 1);
    @(negedge clk);
    cmd_if.req_valid = 1'b0;
    scramble_cfg();
    if (err) begin
      check($sformatf("%s error_pulse", tag), error, 1);
      check($sformatf("%s no_write_on_err", tag), config_write_enable, 0);
      check($sformatf("%s done_on_err", tag), done, 0);
      check($sformatf("%s ready_during_err", tag), cmd_if.req_ready, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        check($sformatf("%s we[%0d]", tag, i), config_write_enable, 1);
        check($sformatf("%s addr[%0d]", tag, i), config_address, wr[i][11:8]);
        check($sformatf("%s data[%0d]", tag, i), write_data, wr[i][7:0]);
        check($sformatf("%s done[%0d]", tag, i), done, (i == n - 1) ? 1 : 0);
        check($sformatf("%s ready[%0d]", tag, i), cmd_if.req_ready, 0);
        check($sformatf("%s busy[%0d]", tag, i), busy, 1);
        check($sformatf("%s error[%0d]", tag, i), error, 0);
      end
    end
    @(negedge clk);
    check($sformatf("%s ready_after", tag), cmd_if.req_ready, 1);
    check($sformatf("%s we_after", tag), config_write_enable, 0);
    check($sformatf("%s done_after", tag), done, 0);
    check($sformatf("%s error_after", tag), error, 0);
  endtask

  typedef struct packed {
    logic [1:0]        op;
    logic [2:0]        pre;
    logic [7:0]        mx, mn, c0, c1;
    logic [3:0]        mode;
    logic              err;
    logic [2:0]        n;
    logic [6:0][11:0]  wr;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [1:0] op, input logic [2:0] pre,
                         input logic [7:0] mx, input logic [7:0] mn,
                         input logic [7:0] c0, input logic [7:0] c1, input logic [3:0] mode,
                         input logic err, input logic [2:0] n,
                         input logic [11:0] w0 = 0, input logic [11:0] w1 = 0,
                         input logic [11:0] w2 = 0, input logic [11:0] w3 = 0,
                         input logic [11:0] w4 = 0, input logic [11:0] w5 = 0,
                         input logic [11:0] w6 = 0);
    vec_t v;
    v.op = op; v.pre = pre; v.mx = mx; v.mn = mn; v.c0 = c0; v.c1 = c1;
    v.mode = mode; v.err = err; v.n = n;
    v.wr[0] = w0; v.wr[1] = w1; v.wr[2] = w2; v.wr[3] = w3;
    v.wr[4] = w4; v.wr[5] = w5; v.wr[6] = w6;
    tbl.push_back(v);
  endtask

  initial begin
    bit               e;
    int               n;
    logic [6:0][11:0] wr;
    logic [1:0]       op;
    logic [2:0]       pre;
    logic [7:0]       mx, mn, c0, c1, t;
    logic [3:0]       mode;

    // Directed vectors: {op, pre, max, min, cmp0, cmp1, mode, err, n, writes}
    add_vec(2'd1, 0, 0,   0,   0,   0,   4'h0, 0, 1, 12'h000);
    add_vec(2'd2, 0, 0,   0,   0,   0,   4'h0, 1, 0);
    add_vec(2'd3, 0, 0,   0,   1,   2,   4'h0, 1, 0);
    add_vec(2'd0, 3, 10,  20,  50,  150, 4'hB, 1, 0);
    add_vec(2'd2, 0, 0,   0,   0,   0,   4'h0, 1, 0);
    add_vec(2'd0, 3, 200, 10,  50,  150, 4'hB, 0, 7,
            12'h016, 12'h103, 12'h2C8, 12'h30A, 12'h432, 12'h596, 12'h017);
    add_vec(2'd2, 0, 0,   0,   0,   0,   4'h0, 0, 2, 12'h016, 12'h017);
    add_vec(2'd3, 0, 0,   0,   7,   9,   4'h0, 0, 2, 12'h407, 12'h509);
    add_vec(2'd2, 0, 0,   0,   0,   0,   4'h5, 0, 2, 12'h016, 12'h017);
    add_vec(2'd0, 1, 10,  20,  1,   1,   4'hF, 1, 0);
    add_vec(2'd2, 0, 0,   0,   0,   0,   4'h0, 0, 2, 12'h016, 12'h017);
    add_vec(2'd1, 0, 0,   0,   0,   0,   4'h0, 0, 1, 12'h016);
    add_vec(2'd0, 7, 255, 255, 0,   255, 4'h5, 0, 7,
            12'h00A, 12'h107, 12'h2FF, 12'h3FF, 12'h400, 12'h5FF, 12'h00B);

    m_valid = 0; m_mode = 0; m_pre = 0; m_max = 0; m_min = 0; m_c0 = 0; m_c1 = 0;
    cmd_if.req_valid = 1'b0;
    scramble_cfg();
    rst = 1'b0;
    #1;
    check("reset ready", cmd_if.req_ready, 1);
    check("reset we", config_write_enable, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset addr", config_address, 0);
    check("reset data", write_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table, applied back-to-back. The model follows along so that
    // the randomized phase starts from the same shadow state.
    for (int k = 0; k < tbl.size(); k++) begin
      model(tbl[k].op, tbl[k].pre, tbl[k].mx, tbl[k].mn, tbl[k].c0, tbl[k].c1,
            tbl[k].mode, e, n, wr);
      run_cmd($sformatf("tbl%0d", k), tbl[k].op, tbl[k].pre, tbl[k].mx, tbl[k].mn,
              tbl[k].c0, tbl[k].c1, tbl[k].mode, tbl[k].err, int'(tbl[k].n), tbl[k].wr);
    end

    // Reset asserted during the 4th write of a LOAD_START.
    @(negedge clk);
    cmd_if.req_valid = 1'b1; cmd_if.req_op = 2'd0; cmd_if.cfg_prescaler = 3'd3;
    cmd_if.cfg_count_max = 8'd200; cmd_if.cfg_count_min = 8'd10;
    cmd_if.cfg_cmp_0 = 8'd50; cmd_if.cfg_cmp_1 = 8'd150; cmd_if.cfg_mode = 4'hB;
    @(negedge clk);
    cmd_if.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst 4th write we", config_write_enable, 1);
    check("midrst 4th write addr", config_address, 4'd3);
    #2 rst = 1'b0;
    #1;
    check("midrst we", config_write_enable, 0);
    check("midrst addr", config_address, 0);
    check("midrst data", write_data, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst ready", cmd_if.req_ready, 1);
    m_valid = 0; m_mode = 0; m_pre = 0; m_max = 0; m_min = 0; m_c0 = 0; m_c1 = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("postrst no write", config_write_enable, 0);
    model(2'd2, 0, 0, 0, 0, 0, 0, e, n, wr);
    run_cmd("postrst restart", 2'd2, 0, 0, 0, 0, 0, 0, e, n, wr);

    // Randomized commands with occasional idle gaps.
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = 2'($urandom); pre = 3'($urandom);
      mx = 8'($urandom); mn = 8'($urandom);
      c0 = 8'($urandom); c1 = 8'($urandom); mode = 4'($urandom);
      if (mn > mx && $urandom_range(0, 3) != 0) begin t = mn; mn = mx; mx = t; end
      model(op, pre, mx, mn, c0, c1, mode, e, n, wr);
      run_cmd($sformatf("rnd%0d", k), op, pre, mx, mn, c0, c1, mode, e, n, wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
